// File: rtl/atm_pin_entry.sv
// PIN-capture stage for the ATM controller: buffers keypad digits during a card
// session, checks them against the account PIN, and handles timeout and lockout.
module atm_pin_entry #(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            card_inserted_i,
  input  logic                            key_valid_i,
  input  logic [3:0]                      key_digit_i,
  input  logic                            key_clear_i,
  input  logic                            key_enter_i,
  input  logic [4*PIN_DIGITS-1:0]         stored_pin_i,
  output logic                            pin_correct_o,
  output logic                            pin_wrong_o,
  output logic                            pin_timeout_o,
  output logic                            card_locked_o,
  output logic [$clog2(PIN_DIGITS+1)-1:0] digit_count_o,
  output logic [2:0]                      attempts_o
);

  localparam int BW = 4 * PIN_DIGITS;
  localparam int CW = $clog2(PIN_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    VERIFY,
    DONE,
    LOCKED
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      attempts_q, attempts_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            correct_q, correct_d;
  logic            wrong_q, wrong_d;
  logic            timeout_q, timeout_d;
  logic            locked_q, locked_d;
  logic            anyKey;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      count_q    <= '0;
      attempts_q <= '0;
      timer_q    <= '0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
      timeout_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
      attempts_q <= attempts_d;
      timer_q    <= timer_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
      timeout_q  <= timeout_d;
      locked_q   <= locked_d;
    end
  end

  // Any strobe restarts the idle timer, even one that is otherwise ignored.
  assign anyKey = key_valid_i | key_clear_i | key_enter_i;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    count_d    = count_q;
    attempts_d = attempts_q;
    timer_d    = timer_q;
    correct_d  = 1'b0;
    wrong_d    = 1'b0;
    timeout_d  = 1'b0;
    locked_d   = locked_q;

    case (state_q)
      IDLE: begin
        if (card_inserted_i) begin
          state_d    = ENTRY;
          buf_d      = '0;
          count_d    = '0;
          attempts_d = '0;
          timer_d    = '0;
        end
      end

      ENTRY: begin
        if (!card_inserted_i) begin
          state_d = IDLE;
          buf_d   = '0;
          count_d = '0;
        end else if (key_clear_i) begin
          buf_d   = '0;
          count_d = '0;
        end else if (key_enter_i) begin
          if (count_q == CW'(PIN_DIGITS)) state_d = VERIFY;
        end else if (key_valid_i) begin
          if (key_digit_i <= 4'd9 && count_q < CW'(PIN_DIGITS)) begin
            buf_d   = (buf_q << 4) | BW'(key_digit_i);
            count_d = count_q + CW'(1);
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          buf_d     = '0;
          state_d   = DONE;
        end

        if (anyKey || timer_q == TW'(TIMEOUT_CYCLES - 1)) timer_d = '0;
        else timer_d = timer_q + TW'(1);
      end

      // Card removal outranks the comparison result.
      VERIFY: begin
        if (!card_inserted_i) begin
          state_d = IDLE;
          buf_d   = '0;
          count_d = '0;
        end else if (buf_q == stored_pin_i) begin
          correct_d = 1'b1;
          state_d   = DONE;
        end else begin
          attempts_d = attempts_q + 3'd1;
          wrong_d    = 1'b1;
          if (attempts_q + 3'd1 == 3'(MAX_ATTEMPTS)) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end else begin
            state_d = ENTRY;
            buf_d   = '0;
            count_d = '0;
            timer_d = '0;
          end
        end
      end

      DONE: begin
        if (!card_inserted_i) state_d = IDLE;
      end

      LOCKED: begin
        locked_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pin_correct_o = correct_q;
  assign pin_wrong_o   = wrong_q;
  assign pin_timeout_o = timeout_q;
  assign card_locked_o = locked_q;
  assign digit_count_o = count_q;
  assign attempts_o    = attempts_q;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Bench for atm_pin_entry: directed vector table, hand-written lockout/timeout/reset
// sequences, and a randomized run against a queue-based reference model.
module tb_atm_pin_entry;

  localparam int PIN_DIGITS     = 4;
  localparam int MAX_ATTEMPTS   = 3;
  localparam int TIMEOUT_CYCLES = 20;

  localparam int M_IDLE   = 0;
  localparam int M_ENTRY  = 1;
  localparam int M_VERIFY = 2;
  localparam int M_DONE   = 3;
  localparam int M_LOCKED = 4;

  logic        clk;
  logic        rst;
  logic        cardInserted;
  logic        keyValid;
  logic [3:0]  keyDigit;
  logic        keyClear;
  logic        keyEnter;
  logic [15:0] storedPin;
  logic        pinCorrect;
  logic        pinWrong;
  logic        pinTimeout;
  logic        cardLocked;
  logic [2:0]  digitCount;
  logic [2:0]  attempts;

  int checks;
  int errors;

  // Reference model: session phase, the entered digits as a queue, and counters.
  int mPhase;
  int mDigits[$];
  int mAttempts;
  int mIdle;
  int eCount;
  bit eCorrect, eWrong, eTimeout, eLocked;

  typedef struct {
    bit         card;
    bit         kv;
    logic [3:0] digit;
    bit         clr;
    bit         ent;
    bit         expCorrect;
    bit         expWrong;
    int         expCount;
    int         expAttempts;
  } vec_t;

  vec_t vecs[$];

  atm_pin_entry #(
    .PIN_DIGITS    (PIN_DIGITS),
    .MAX_ATTEMPTS  (MAX_ATTEMPTS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .card_inserted_i(cardInserted),
    .key_valid_i    (keyValid),
    .key_digit_i    (keyDigit),
    .key_clear_i    (keyClear),
    .key_enter_i    (keyEnter),
    .stored_pin_i   (storedPin),
    .pin_correct_o  (pinCorrect),
    .pin_wrong_o    (pinWrong),
    .pin_timeout_o  (pinTimeout),
    .card_locked_o  (cardLocked),
    .digit_count_o  (digitCount),
    .attempts_o     (attempts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPhase    = M_IDLE;
    mDigits.delete();
    mAttempts = 0;
    mIdle     = 0;
    eCount    = 0;
    eCorrect  = 0;
    eWrong    = 0;
    eTimeout  = 0;
    eLocked   = 0;
  endtask

  function automatic longint digitsValue();
    longint v = 0;
    foreach (mDigits[i]) v = v * 16 + mDigits[i];
    return v;
  endfunction

  // One clock edge of the behavioural model, using the inputs present at the edge.
  task automatic modelStep();
    eCorrect = 0;
    eWrong   = 0;
    eTimeout = 0;
    if (rst) begin
      modelReset();
      return;
    end
    case (mPhase)
      M_IDLE: if (cardInserted) begin
        mPhase = M_ENTRY;
        mDigits.delete();
        eCount = 0;
        mAttempts = 0;
        mIdle = 0;
      end
      M_ENTRY: begin
        if (!cardInserted) begin
          mPhase = M_IDLE;
          mDigits.delete();
          eCount = 0;
        end else if (keyClear) begin
          mDigits.delete();
          eCount = 0;
          mIdle = 0;
        end else if (keyEnter) begin
          mIdle = 0;
          if (mDigits.size() == PIN_DIGITS) mPhase = M_VERIFY;
        end else if (keyValid) begin
          mIdle = 0;
          if (keyDigit <= 9 && mDigits.size() < PIN_DIGITS) begin
            mDigits.push_back(int'(keyDigit));
            eCount = mDigits.size();
          end
        end else begin
          mIdle++;
          if (mIdle == TIMEOUT_CYCLES) begin
            eTimeout = 1;
            mDigits.delete();
            mPhase = M_DONE;
            mIdle = 0;
          end
        end
      end
      M_VERIFY: begin
        if (!cardInserted) begin
          mPhase = M_IDLE;
          mDigits.delete();
          eCount = 0;
        end else if (digitsValue() == longint'(storedPin)) begin
          eCorrect = 1;
          mPhase = M_DONE;
        end else begin
          mAttempts++;
          eWrong = 1;
          if (mAttempts == MAX_ATTEMPTS) begin
            mPhase = M_LOCKED;
            eLocked = 1;
          end else begin
            mPhase = M_ENTRY;
            mDigits.delete();
            eCount = 0;
            mIdle = 0;
          end
        end
      end
      M_DONE: if (!cardInserted) mPhase = M_IDLE;
      default: ;
    endcase
  endtask

  // Advance one edge, step the model, and compare every output to it.
  task automatic stepClock();
    @(posedge clk);
    modelStep();
    #1;
    checkValue("model", {pinCorrect, pinWrong, pinTimeout, cardLocked, digitCount, attempts},
               {eCorrect, eWrong, eTimeout, eLocked, 3'(eCount), 3'(mAttempts)});
  endtask

  task automatic applyStimulus(input bit card, input bit kv, input logic [3:0] digit,
                               input bit clr, input bit ent);
    cardInserted = card;
    keyValid     = kv;
    keyDigit     = digit;
    keyClear     = clr;
    keyEnter     = ent;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    checkValue({name, ".correct"}, int'(pinCorrect), int'(v.expCorrect));
    checkValue({name, ".wrong"}, int'(pinWrong), int'(v.expWrong));
    checkValue({name, ".count"}, int'(digitCount), v.expCount);
    checkValue({name, ".attempts"}, int'(attempts), v.expAttempts);
  endtask

  task automatic addVec(input bit card, input bit kv, input logic [3:0] digit, input bit clr,
                        input bit ent, input bit c, input bit w, input int cnt, input int att);
    vec_t v;
    v.card = card; v.kv = kv; v.digit = digit; v.clr = clr; v.ent = ent;
    v.expCorrect = c; v.expWrong = w; v.expCount = cnt; v.expAttempts = att;
    vecs.push_back(v);
  endtask

  task automatic pressKey(input logic [3:0] d);
    applyStimulus(1, 1, d, 0, 0);
    stepClock();
  endtask

  task automatic idleCycle(input bit card);
    applyStimulus(card, 0, 4'd0, 0, 0);
    stepClock();
  endtask

  task automatic enterPin(input logic [15:0] pin);
    logic [15:0] p;
    p = pin;
    for (int i = 3; i >= 0; i--) pressKey(p[4*i +: 4]);
    applyStimulus(1, 0, 4'd0, 0, 1);
    stepClock();
    idleCycle(1);
  endtask

  task automatic asyncResetCheck(input string name);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkValue({name, ".outputs"},
               {pinCorrect, pinWrong, pinTimeout, cardLocked, digitCount, attempts}, 0);
    applyStimulus(0, 0, 4'd0, 0, 0);
    stepClock();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    modelReset();
    storedPin = 16'h1234;
    rst = 1'b1;
    applyStimulus(0, 0, 4'd0, 0, 0);
    #1;
    checkValue("reset.outputs",
               {pinCorrect, pinWrong, pinTimeout, cardLocked, digitCount, attempts}, 0);
    stepClock();
    rst = 1'b0;

    // Correct PIN, wrong PIN, rejected keys, and clear-over-enter priority.
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, 1, 0, 0, 0, 0, 1, 0);
    addVec(1, 1, 2, 0, 0, 0, 0, 2, 0);
    addVec(1, 1, 3, 0, 0, 0, 0, 3, 0);
    addVec(1, 1, 4, 0, 0, 0, 0, 4, 0);
    addVec(1, 0, 0, 0, 1, 0, 0, 4, 0);
    addVec(1, 0, 0, 0, 0, 1, 0, 4, 0);
    addVec(1, 0, 0, 0, 0, 0, 0, 4, 0);
    addVec(1, 1, 5, 0, 0, 0, 0, 4, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 4, 0);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, 1, 0, 0, 0, 0, 1, 0);
    addVec(1, 1, 2, 0, 0, 0, 0, 2, 0);
    addVec(1, 1, 3, 0, 0, 0, 0, 3, 0);
    addVec(1, 1, 5, 0, 0, 0, 0, 4, 0);
    addVec(1, 0, 0, 0, 1, 0, 0, 4, 0);
    addVec(1, 0, 0, 0, 0, 0, 1, 0, 1);
    addVec(1, 1, 1, 0, 0, 0, 0, 1, 1);
    addVec(1, 1, 2, 0, 0, 0, 0, 2, 1);
    addVec(1, 1, 3, 0, 0, 0, 0, 3, 1);
    addVec(1, 0, 0, 0, 1, 0, 0, 3, 1);
    addVec(1, 1, 4'hA, 0, 0, 0, 0, 3, 1);
    addVec(1, 1, 4, 0, 0, 0, 0, 4, 1);
    addVec(1, 1, 5, 0, 0, 0, 0, 4, 1);
    addVec(1, 0, 0, 1, 0, 0, 0, 0, 1);
    addVec(1, 1, 1, 0, 0, 0, 0, 1, 1);
    addVec(1, 0, 0, 1, 1, 0, 0, 0, 1);
    addVec(1, 1, 1, 0, 0, 0, 0, 1, 1);
    addVec(1, 1, 2, 0, 0, 0, 0, 2, 1);
    addVec(1, 1, 3, 0, 0, 0, 0, 3, 1);
    addVec(1, 1, 4, 0, 0, 0, 0, 4, 1);
    addVec(1, 0, 0, 1, 1, 0, 0, 0, 1);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 1, 1, 0, 0, 0, 0, 1, 1);
    addVec(1, 1, 2, 0, 0, 0, 0, 2, 1);
    addVec(1, 1, 3, 0, 0, 0, 0, 3, 1);
    addVec(1, 1, 4, 0, 0, 0, 0, 4, 1);
    addVec(1, 0, 0, 0, 1, 0, 0, 4, 1);
    addVec(1, 0, 0, 0, 0, 1, 0, 4, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 4, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].card, vecs[i].kv, vecs[i].digit, vecs[i].clr, vecs[i].ent);
      stepClock();
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Three wrong entries lock the card on the third pulse; only reset releases it.
    idleCycle(1);
    enterPin(16'h9999);
    checkValue("lock.wrong1", int'(pinWrong), 1);
    enterPin(16'h1243);
    checkValue("lock.wrong2", {pinWrong, cardLocked, attempts}, {1'b1, 1'b0, 3'd2});
    enterPin(16'h0000);
    checkValue("lock.wrong3", {pinWrong, cardLocked, attempts}, {1'b1, 1'b1, 3'd3});
    pressKey(4'd1);
    applyStimulus(1, 0, 4'd0, 1, 1);
    stepClock();
    idleCycle(0);
    idleCycle(0);
    checkValue("lock.held", int'(cardLocked), 1);
    asyncResetCheck("lock.rst");

    // Inactivity timeout after exactly TIMEOUT_CYCLES idle edges.
    idleCycle(1);
    pressKey(4'd1);
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) idleCycle(1);
    checkValue("timeout.early", int'(pinTimeout), 0);
    idleCycle(1);
    checkValue("timeout.pulse", int'(pinTimeout), 1);
    idleCycle(1);
    checkValue("timeout.single", int'(pinTimeout), 0);
    pressKey(4'd2);
    applyStimulus(1, 0, 4'd0, 0, 1);
    stepClock();
    idleCycle(1);
    checkValue("timeout.done", {pinCorrect, pinWrong, digitCount}, {1'b0, 1'b0, 3'd1});

    // Card removal mid-entry, then asynchronous reset mid-entry.
    idleCycle(0);
    idleCycle(1);
    pressKey(4'd7);
    pressKey(4'd8);
    idleCycle(0);
    checkValue("removal", {pinCorrect, pinWrong, pinTimeout, digitCount}, 0);
    idleCycle(1);
    pressKey(4'd3);
    pressKey(4'd4);
    checkValue("midentry.count", int'(digitCount), 2);
    asyncResetCheck("midentry.rst");

    // Randomized traffic against the reference model.
    storedPin = 16'h1212;
    for (int seg = 0; seg < 40; seg++) begin
      int keyRate;
      keyRate = $urandom_range(5, 90);
      for (int c = 0; c < 60; c++) begin
        bit card;
        card = ($urandom_range(0, 99) < 96) ? cardInserted : ~cardInserted;
        if ($urandom_range(0, 99) < keyRate)
          applyStimulus(card, $urandom_range(0, 99) < 80,
                        ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                     : 4'($urandom_range(1, 2)),
                        $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 25);
        else
          applyStimulus(card, 0, 4'd0, 0, 0);
        stepClock();
      end
      if (seg % 4 == 3) asyncResetCheck("rand.rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
